// File: rtl/seg7_scan_disp.sv
// Multiplexed 8-digit common-anode seven-segment driver with per-frame input snapshot, decimal point and blink.
// Optional anti-ghosting gap at the start of each digit slot is enabled by defining SEG7_GHOST_BLANK_EN.
module seg7_scan_disp #(
  parameter int SCAN_TICKS  = 50000,
  parameter int BLINK_TICKS = 25000000,
  parameter int BLANK_TICKS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] disp_num,
  input  logic [7:0]  point_in,
  input  logic [7:0]  blink_in,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int SW = (SCAN_TICKS  > 2) ? $clog2(SCAN_TICKS)  : 1;
  localparam int BW = (BLINK_TICKS > 2) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_TICKS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);
  localparam logic [SW-1:0] BLANK_END  = SW'(BLANK_TICKS);
`ifdef SEG7_GHOST_BLANK_EN
  localparam logic GAP_EN = 1'b1;
`else
  localparam logic GAP_EN = 1'b0;
`endif

  // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
  function automatic logic [6:0] hexcode(input logic [3:0] nib);
    case (nib)
      4'h0:    hexcode = 7'h40;
      4'h1:    hexcode = 7'h79;
      4'h2:    hexcode = 7'h24;
      4'h3:    hexcode = 7'h30;
      4'h4:    hexcode = 7'h19;
      4'h5:    hexcode = 7'h12;
      4'h6:    hexcode = 7'h02;
      4'h7:    hexcode = 7'h78;
      4'h8:    hexcode = 7'h00;
      4'h9:    hexcode = 7'h10;
      4'hA:    hexcode = 7'h08;
      4'hB:    hexcode = 7'h03;
      4'hC:    hexcode = 7'h46;
      4'hD:    hexcode = 7'h21;
      4'hE:    hexcode = 7'h06;
      4'hF:    hexcode = 7'h0E;
      default: hexcode = 7'h7F;
    endcase
  endfunction

  logic [SW-1:0] scan_cnt_r;
  logic [2:0]    idx_r;
  logic [BW-1:0] blink_cnt_r;
  logic          phase_r;
  logic [31:0]   data_r;
  logic [7:0]    point_r;
  logic [7:0]    blink_r;
  logic [7:0]    an_r;
  logic [7:0]    seg_r;

  logic          scan_wrap_s;
  logic          blink_wrap_s;
  logic          load_s;
  logic          blank_s;
  logic [3:0]    digit_s;
  logic [7:0]    an_nxt_s;
  logic [7:0]    seg_nxt_s;

  // Wrap/load strobes and next output pattern for the slot currently selected by idx_r.
  always_comb begin
    scan_wrap_s  = (scan_cnt_r == SCAN_LAST);
    blink_wrap_s = (blink_cnt_r == BLINK_LAST);
    load_s       = scan_wrap_s && (idx_r == 3'd7) && en;
    blank_s      = GAP_EN && (scan_cnt_r < BLANK_END);
    digit_s      = data_r[{idx_r, 2'b00} +: 4];
    seg_nxt_s    = {~point_r[idx_r], hexcode(digit_s)};
    an_nxt_s     = ~(8'b0000_0001 << idx_r);
    if ((phase_r && blink_r[idx_r]) || blank_s) begin
      an_nxt_s = 8'hFF;
    end else begin
      an_nxt_s = ~(8'b0000_0001 << idx_r);
    end
  end

  // Digit slot timer and digit index.
  always_ff @(posedge clk) begin
    if (!rst) begin
      scan_cnt_r <= '0;
      idx_r      <= 3'd0;
    end else if (scan_wrap_s) begin
      scan_cnt_r <= '0;
      idx_r      <= idx_r + 3'd1;
    end else begin
      scan_cnt_r <= scan_cnt_r + {{(SW-1){1'b0}}, 1'b1};
      idx_r      <= idx_r;
    end
  end

  // Free-running blink half-period timer, independent of scanning.
  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_cnt_r <= '0;
      phase_r     <= 1'b0;
    end else if (blink_wrap_s) begin
      blink_cnt_r <= '0;
      phase_r     <= ~phase_r;
    end else begin
      blink_cnt_r <= blink_cnt_r + {{(BW-1){1'b0}}, 1'b1};
      phase_r     <= phase_r;
    end
  end

  // Snapshot only at the last cycle of digit 7 so a frame never mixes old and new data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_r  <= 32'h0000_0000;
      point_r <= 8'h00;
      blink_r <= 8'h00;
    end else if (load_s) begin
      data_r  <= disp_num;
      point_r <= point_in;
      blink_r <= blink_in;
    end else begin
      data_r  <= data_r;
      point_r <= point_r;
      blink_r <= blink_r;
    end
  end

  // Registered display drive.
  always_ff @(posedge clk) begin
    if (!rst) begin
      an_r  <= 8'hFF;
      seg_r <= 8'hFF;
    end else begin
      an_r  <= an_nxt_s;
      seg_r <= seg_nxt_s;
    end
  end

  assign an  = an_r;
  assign seg = seg_r;

endmodule
